// File: rtl/mrd_pkg.sv
// Shared definitions for the mrd memory bank blocks: bank state codes,
// frame size limits and the sink-side FSM encoding.
package mrd_pkg;

    // Bank state codes driven by the top control FSM
    localparam logic [1:0] MRD_ST_SINK = 2'b00;
    localparam logic [1:0] MRD_ST_RD   = 2'b01;
    localparam logic [1:0] MRD_ST_WR   = 2'b10;
    localparam logic [1:0] MRD_ST_SRC  = 2'b11;

    localparam int MRD_DW      = 16;
    localparam int MRD_MAX_PTS = 1200;
    localparam int MRD_MIN_PTS = 12;
    localparam int MRD_PTS_W   = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SINK = 2'd1,
        DONE = 2'd2
    } sink_st_t;

endpackage

// File: rtl/mrd_sink_ctrl_if.sv
// Streaming sample input of one bank: valid/ready handshake with frame
// delimiters, complex sample and the frame length carried on the sop beat.
interface mrd_sink_ctrl_if #(
    parameter int DW = 16
);
    logic          sink_valid;
    logic          sink_ready;
    logic          sink_sop;
    logic          sink_eop;
    logic [DW-1:0] sink_real;
    logic [DW-1:0] sink_imag;
    logic [11:0]   sink_dftpts;

    modport master (
        output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_dftpts,
        input  sink_ready
    );

    modport slave (
        input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_dftpts,
        output sink_ready
    );
endinterface

// File: rtl/mrd_sink_ctrl.sv
// Input stage of one ping-pong bank: accepts a DFT frame, checks its length
// against the sop-time dftpts, writes samples linearly into the bank RAM and
// reports frame start/ongoing/done status to the control FSM.
module mrd_sink_ctrl
    import mrd_pkg::*;
#(
    parameter int DW      = 16,
    parameter int AW      = 11,
    parameter int MAX_PTS = 1200,
    parameter int MIN_PTS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           ctrl_state,
    mrd_sink_ctrl_if.slave       sink,
    output logic                 stat_sink_sop,
    output logic [MRD_PTS_W-1:0] stat_dftpts,
    output logic                 stat_sink_ong,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_real,
    output logic [DW-1:0]        wr_imag,
    output logic                 frame_done,
    output logic                 err_len,
    output logic                 err_pts,
    output logic                 err_nosop
);

    localparam logic [MRD_PTS_W-1:0] PTS_MAX = MRD_PTS_W'(MAX_PTS);
    localparam logic [MRD_PTS_W-1:0] PTS_MIN = MRD_PTS_W'(MIN_PTS);

    sink_st_t             state, state_nxt;
    logic [AW-1:0]        cnt, cnt_nxt;
    logic [AW-1:0]        addr_nxt;
    logic [MRD_PTS_W-1:0] last_idx;
    logic                 ready, acc, pts_ok, is_last;
    logic                 wr_nxt, start, len_e, pts_e, nosop_e, drop;

    assign sink.sink_ready = ready;

    // Handshake, frame checks and next-state/write decisions for the accepted beat
    always_comb begin
        ready     = rst_n && (ctrl_state == MRD_ST_SINK) && (state != DONE);
        acc       = sink.sink_valid && ready;
        pts_ok    = (sink.sink_dftpts >= PTS_MIN) && (sink.sink_dftpts <= PTS_MAX);
        last_idx  = stat_dftpts - 1'b1;
        is_last   = (MRD_PTS_W'(cnt) == last_idx);
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = cnt;
        wr_nxt    = 1'b0;
        start     = 1'b0;
        len_e     = 1'b0;
        pts_e     = 1'b0;
        nosop_e   = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (acc && sink.sink_sop) begin
                    if (pts_ok) begin
                        start     = 1'b1;
                        wr_nxt    = 1'b1;
                        addr_nxt  = '0;
                        cnt_nxt   = AW'(1);
                        len_e     = sink.sink_eop;
                        state_nxt = sink.sink_eop ? DONE : SINK;
                    end else begin
                        pts_e = 1'b1;
                    end
                end else if (acc) begin
                    nosop_e = 1'b1;
                end
            end
            SINK: begin
                if (acc && sink.sink_sop) begin
                    // A sop inside a frame aborts it and restarts like IDLE
                    len_e = 1'b1;
                    if (pts_ok) begin
                        start     = 1'b1;
                        wr_nxt    = 1'b1;
                        addr_nxt  = '0;
                        cnt_nxt   = AW'(1);
                        state_nxt = sink.sink_eop ? DONE : SINK;
                    end else begin
                        pts_e     = 1'b1;
                        drop      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end else if (acc) begin
                    wr_nxt = 1'b1;
                    if (is_last) begin
                        len_e     = !sink.sink_eop;
                        state_nxt = DONE;
                    end else if (sink.sink_eop) begin
                        len_e     = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM, sample counter, registered write port and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_real       <= '0;
            wr_imag       <= '0;
            stat_sink_sop <= 1'b0;
            stat_dftpts   <= '0;
            stat_sink_ong <= 1'b0;
            frame_done    <= 1'b0;
            err_len       <= 1'b0;
            err_pts       <= 1'b0;
            err_nosop     <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            wr_en         <= wr_nxt;
            stat_sink_sop <= start;
            frame_done    <= (state == DONE);
            err_len       <= len_e;
            err_pts       <= pts_e;
            err_nosop     <= nosop_e;
            if (wr_nxt) begin
                wr_addr <= addr_nxt;
                wr_real <= sink.sink_real;
                wr_imag <= sink.sink_imag;
            end
            if (start)
                stat_dftpts <= sink.sink_dftpts;
            // Ongoing stays up through the frame_done cycle, drops on the edge after
            if (start)
                stat_sink_ong <= 1'b1;
            else if (frame_done || drop)
                stat_sink_ong <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mrd_sink_ctrl.sv
// Directed bench for mrd_sink_ctrl: full frames, early eop, illegal dftpts,
// ctrl_state gating, in-frame restart and asynchronous reset mid-frame.
module tb_mrd_sink_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ctrl_state;
    logic        stat_sink_sop;
    logic [11:0] stat_dftpts;
    logic        stat_sink_ong;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [15:0] wr_real;
    logic [15:0] wr_imag;
    logic        frame_done;
    logic        err_len;
    logic        err_pts;
    logic        err_nosop;

    int errors = 0;
    int checks = 0;
    int seq_bad;
    int nwr;

    mrd_sink_ctrl_if #(.DW(16)) sif ();

    mrd_sink_ctrl #(.DW(16), .AW(11), .MAX_PTS(1200), .MIN_PTS(12)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ctrl_state    (ctrl_state),
        .sink          (sif),
        .stat_sink_sop (stat_sink_sop),
        .stat_dftpts   (stat_dftpts),
        .stat_sink_ong (stat_sink_ong),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_real       (wr_real),
        .wr_imag       (wr_imag),
        .frame_done    (frame_done),
        .err_len       (err_len),
        .err_pts       (err_pts),
        .err_nosop     (err_nosop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one beat and let one edge pass; outputs are sampled 1 ns later
    task automatic beat(input logic sop, input logic eop, input int pts, input int idx);
        sif.sink_valid  = 1'b1;
        sif.sink_sop    = sop;
        sif.sink_eop    = eop;
        sif.sink_dftpts = 12'(pts);
        sif.sink_real   = 16'(idx);
        sif.sink_imag   = ~16'(idx);
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sif.sink_valid = 1'b0;
        sif.sink_sop   = 1'b0;
        sif.sink_eop   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Beats lo..hi of a frame (address == beat index); sop on index 0,
    // eop on eop_idx. Mismatches accumulate into seq_bad, writes into nwr.
    task automatic frame_beats(input int lo, input int hi, input int pts, input int eop_idx);
        for (int i = lo; i <= hi; i++) begin
            #1;
            if (sif.sink_ready !== 1'b1) seq_bad++;
            beat(i == 0, i == eop_idx, pts, i);
            if (wr_en === 1'b1) nwr++;
            if (wr_en !== 1'b1 || wr_addr !== 11'(i) || wr_real !== 16'(i) || wr_imag !== ~16'(i))
                seq_bad++;
            if (i != hi && (err_len !== 1'b0 || frame_done !== 1'b0)) seq_bad++;
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        ctrl_state      = 2'b00;
        sif.sink_valid  = 1'b0;
        sif.sink_sop    = 1'b0;
        sif.sink_eop    = 1'b0;
        sif.sink_real   = '0;
        sif.sink_imag   = '0;
        sif.sink_dftpts = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_ong", stat_sink_ong, 0);
        chk("rst_dftpts", stat_dftpts, 0);
        chk("rst_ready", sif.sink_ready, 0);
        chk("rst_done", {frame_done, err_len, err_pts, err_nosop, stat_sink_sop}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1) full 1200-point frame
        seq_bad = 0; nwr = 0;
        beat(1'b1, 1'b0, 1200, 0);
        chk("f1_sop", stat_sink_sop, 1);
        chk("f1_ong", stat_sink_ong, 1);
        chk("f1_dftpts", stat_dftpts, 1200);
        chk("f1_addr0", {wr_en, wr_addr}, {1'b1, 11'd0});
        frame_beats(1, 1199, 1200, 1199);
        chk("f1_seq", seq_bad, 0);
        chk("f1_nwr", nwr, 1199);
        chk("f1_last_err", err_len, 0);
        chk("f1_ready_done", sif.sink_ready, 0);
        chk("f1_done_early", frame_done, 0);
        tick();
        chk("f1_done", frame_done, 1);
        chk("f1_ong_done", stat_sink_ong, 1);
        chk("f1_nowr", wr_en, 0);
        tick();
        chk("f1_done_pulse", frame_done, 0);
        chk("f1_ong_low", stat_sink_ong, 0);

        // 2) dftpts=12 with eop at beat 8
        seq_bad = 0; nwr = 0;
        frame_beats(0, 8, 12, 8);
        chk("f2_seq", seq_bad, 0);
        chk("f2_err_len", err_len, 1);
        chk("f2_addr8", wr_addr, 8);
        tick();
        chk("f2_done", frame_done, 1);
        chk("f2_err_pulse", err_len, 0);
        chk("f2_ong_hold", stat_sink_ong, 1);
        tick();
        chk("f2_ong_low", stat_sink_ong, 0);

        // 3) illegal frame lengths and a stray non-sop beat
        beat(1'b1, 1'b0, 5, 0);
        chk("f3_pts5", {err_pts, wr_en, stat_sink_sop}, 3'b100);
        tick();
        chk("f3_pts_pulse", err_pts, 0);
        beat(1'b1, 1'b0, 2000, 0);
        chk("f3_pts2000", {err_pts, wr_en, stat_sink_sop}, 3'b100);
        chk("f3_dftpts_held", stat_dftpts, 12);
        chk("f3_ong", stat_sink_ong, 0);
        beat(1'b0, 1'b0, 12, 3);
        chk("f3_nosop", {err_nosop, wr_en, err_pts}, 3'b100);
        tick();

        // 4) ctrl_state gating, also mid-frame
        ctrl_state = 2'b01;
        sif.sink_valid = 1'b1;
        #1;
        chk("f4_ready_off", sif.sink_ready, 0);
        beat(1'b1, 1'b0, 12, 0);
        chk("f4_blocked", {wr_en, stat_sink_sop}, 0);
        ctrl_state = 2'b00;
        seq_bad = 0; nwr = 0;
        frame_beats(0, 4, 12, -1);
        chk("f4_sop", stat_sink_sop, 0);
        ctrl_state = 2'b01;
        #1;
        chk("f4_hold_ready", sif.sink_ready, 0);
        beat(1'b0, 1'b0, 12, 5);
        chk("f4_hold_nowr", wr_en, 0);
        ctrl_state = 2'b00;
        frame_beats(5, 11, 12, 11);
        chk("f4_seq", seq_bad, 0);
        chk("f4_nwr", nwr, 12);
        chk("f4_noerr", err_len, 0);
        tick();
        chk("f4_done", frame_done, 1);
        tick();

        // 5) second sop at beat 50 of a 600-point frame
        seq_bad = 0; nwr = 0;
        frame_beats(0, 49, 600, -1);
        beat(1'b1, 1'b0, 600, 0);
        chk("f5_restart", {err_len, stat_sink_sop, wr_en}, 3'b111);
        chk("f5_addr0", wr_addr, 0);
        chk("f5_done_none", frame_done, 0);
        frame_beats(1, 599, 600, 599);
        chk("f5_seq", seq_bad, 0);
        chk("f5_noerr", err_len, 0);
        tick();
        chk("f5_done", frame_done, 1);
        tick();

        // 6) asynchronous reset in the middle of a frame
        seq_bad = 0; nwr = 0;
        frame_beats(0, 299, 600, -1);
        chk("f6_pre", {stat_sink_ong, stat_dftpts}, {1'b1, 12'd600});
        #2;
        rst_n = 1'b0;
        #1;
        chk("f6_rst_out", {wr_en, stat_sink_ong, frame_done, err_len}, 0);
        chk("f6_rst_dftpts", stat_dftpts, 0);
        chk("f6_rst_addr", wr_addr, 0);
        sif.sink_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        frame_beats(0, 11, 12, 11);
        chk("f6_seq", seq_bad, 0);
        chk("f6_noerr", err_len, 0);
        tick();
        chk("f6_done", frame_done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
